// File: rtl/arb_pkg.sv
// Shared constants for the RAM arbiter: FSM state encoding and bus width defaults.
package arb_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;  // no owner, arbitrating
    localparam logic [1:0] ST_BUSY = 2'd1;  // owner granted for one transaction
    localparam logic [1:0] ST_LOCK = 2'd2;  // owner holds the RAM across transactions

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after ptr
// (wrapping modulo N) as a one-hot vector, plus a flag that any request is present.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          any
);

    logic [N-1:0] rot;
    logic [N-1:0] rot_grant;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot       = N'({req, req} >> ptr);
        rot_grant = rot & (~rot + N'(1));
        grant     = N'(({rot_grant, rot_grant} << ptr) >> N);
        any       = |req;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between N_PORTS caches. A grant covers
// one transaction; a cache holding c_atomic keeps ownership across several.
module ram_arbiter
    import arb_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int PW      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_PORTS-1:0]    c_read,
    input  logic [N_PORTS-1:0]    c_write,
    input  logic [N_PORTS*AW-1:0] c_addr,
    input  logic [N_PORTS*DW-1:0] c_data_w,
    input  logic [N_PORTS-1:0]    c_atomic,
    output logic [N_PORTS-1:0]    c_wait,
    output logic [DW-1:0]         c_data_r,
    output logic [N_PORTS-1:0]    c_permit,
    output logic                  m_read,
    output logic                  m_write,
    output logic [AW-1:0]         m_addr,
    output logic [DW-1:0]         m_data_w,
    input  logic                  m_wait,
    input  logic [DW-1:0]         m_data_r
);

    state_t               state;
    logic [PW-1:0]        rr_ptr;
    logic [N_PORTS-1:0]   req;
    logic [N_PORTS-1:0]   pick_grant;
    logic                 pick_any;
    logic                 active;
    logic                 done;

    logic [AW-1:0]        sel_addr;
    logic [DW-1:0]        sel_data;
    logic                 sel_read;
    logic                 sel_write;
    logic                 owner_req;
    logic                 owner_atomic;
    logic [PW-1:0]        nxt_ptr;

    assign req = c_read | c_write;

    rr_pick #(
        .N  (N_PORTS),
        .PW (PW)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .any   (pick_any)
    );

    // Select the owner's request fields and its successor pointer off the one-hot permit.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        sel_addr     = '0;
        sel_data     = '0;
        sel_read     = 1'b0;
        sel_write    = 1'b0;
        owner_atomic = 1'b0;
        nxt_ptr      = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (c_permit[k]) begin
                sel_addr     = c_addr[k*AW +: AW];
                sel_data     = c_data_w[k*DW +: DW];
                sel_write    = c_write[k];
                sel_read     = c_read[k] & ~c_write[k];  // write wins when both are high
                owner_atomic = c_atomic[k];
                nxt_ptr      = (k == N_PORTS - 1) ? '0 : PW'(k + 1);
            end
        end
        owner_req = sel_read | sel_write;
    end

    // The RAM only sees the owner while a grant is live; state resets
    // asynchronously, so strobes drop the moment rst_n falls.
    assign active   = (state == ST_BUSY) || (state == ST_LOCK);
    assign m_read   = active & sel_read;
    assign m_write  = active & sel_write;
    assign m_addr   = active ? sel_addr : '0;
    assign m_data_w = active ? sel_data : '0;
    assign c_data_r = m_data_r;
    assign done     = (m_read | m_write) & ~m_wait;

    // The owner follows the RAM stall; everybody else waiting is held off.
    assign c_wait = active ? ((req & ~c_permit) | (c_permit & {N_PORTS{m_wait}})) : req;

    // Arbitration FSM: grant in IDLE, one transfer in BUSY, held transfers in LOCK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            c_permit <= '0;
            rr_ptr   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        c_permit <= pick_grant;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (done && owner_atomic) begin
                        state <= ST_LOCK;
                    end else if (done || !owner_req) begin
                        state    <= ST_IDLE;
                        c_permit <= '0;
                        rr_ptr   <= nxt_ptr;
                    end
                end
                ST_LOCK: begin
                    if (!owner_atomic && (!owner_req || done)) begin
                        state    <= ST_IDLE;
                        c_permit <= '0;
                        rr_ptr   <= nxt_ptr;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    c_permit <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: cycle-stepped requester/RAM model with
// per-port scoreboards, a table of single-port vectors and hand-written corner cases.
module tb_ram_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int PW = 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    c_read;
    logic [N-1:0]    c_write;
    logic [N*AW-1:0] c_addr;
    logic [N*DW-1:0] c_data_w;
    logic [N-1:0]    c_atomic;
    logic [N-1:0]    c_wait;
    logic [DW-1:0]   c_data_r;
    logic [N-1:0]    c_permit;
    logic            m_read;
    logic            m_write;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_data_w;
    logic            m_wait;
    logic [DW-1:0]   m_data_r;

    ram_arbiter #(.N_PORTS(N), .AW(AW), .DW(DW), .PW(PW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .c_read   (c_read),
        .c_write  (c_write),
        .c_addr   (c_addr),
        .c_data_w (c_data_w),
        .c_atomic (c_atomic),
        .c_wait   (c_wait),
        .c_data_r (c_data_r),
        .c_permit (c_permit),
        .m_read   (m_read),
        .m_write  (m_write),
        .m_addr   (m_addr),
        .m_data_w (m_data_w),
        .m_wait   (m_wait),
        .m_data_r (m_data_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          atomic;
    } txn_t;

    typedef struct {
        int            port;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            stall;
        logic          exp_read;
        logic          exp_write;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    txn_t pq  [N][$];
    txn_t sb  [N][$];
    txn_t cur [N];
    logic active [N];
    logic done_flag [N];
    logic seen_permit [N];
    int   req_cycle [N];
    int   grant_cycle [N];
    int   fall_cycle [N];
    int   grant_log [$];
    int   stall_target = 0;
    int   stall_cnt = 0;
    logic last_m_read;
    logic last_m_write;
    logic [N-1:0] prev_atomic;
    vec_t vecs [6];

    function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit busy();
        for (int k = 0; k < N; k++)
            if (active[k] || pq[k].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_ports();
        c_read   = '0;
        c_write  = '0;
        c_addr   = '0;
        c_data_w = '0;
        c_atomic = '0;
        for (int k = 0; k < N; k++) begin
            if (active[k]) begin
                c_read[k]             = cur[k].rd;
                c_write[k]            = cur[k].wr;
                c_addr[k*AW +: AW]    = cur[k].addr;
                c_data_w[k*DW +: DW]  = cur[k].data;
                c_atomic[k]           = cur[k].atomic;
            end
        end
    endtask

    task automatic clear_all();
        for (int k = 0; k < N; k++) begin
            pq[k].delete();
            sb[k].delete();
            active[k]    = 1'b0;
            done_flag[k] = 1'b0;
        end
        drive_ports();
        prev_atomic = '0;
        stall_cnt   = 0;
        m_wait      = 1'b1;
        m_data_r    = '0;
    endtask

    task automatic monitor();
        int   own;
        int   npermit;
        txn_t e;
        own = -1;
        npermit = 0;
        for (int k = 0; k < N; k++)
            if (c_permit[k]) begin
                own = k;
                npermit++;
            end
        check("permit_onehot", 64'(npermit <= 1), 64'(1));
        if (own < 0) check("idle_strobes", 64'({m_read, m_write}), 64'(0));
        for (int k = 0; k < N; k++)
            if (active[k] && k != own) check($sformatf("stall_other_p%0d", k), 64'(c_wait[k]), 64'(1));
        if (own >= 0) begin
            if (active[own] && !seen_permit[own]) begin
                seen_permit[own] = 1'b1;
                grant_cycle[own] = cyc;
            end
            if ((m_read || m_write) && !m_wait) begin
                check("owner_go", 64'(c_wait[own]), 64'(0));
                if (sb[own].size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected: port %0d transferred with nothing expected", own);
                end else begin
                    e = sb[own].pop_front();
                    check("xfer_write", 64'(m_write), 64'(e.wr));
                    check("xfer_read", 64'(m_read), 64'(e.rd & ~e.wr));
                    check("xfer_addr", 64'(m_addr), 64'(e.addr));
                    if (e.wr) check("xfer_wdata", 64'(m_data_w), 64'(e.data));
                    else      check("xfer_rdata", 64'(c_data_r), 64'(rd_fn(e.addr)));
                end
                last_m_read  = m_read;
                last_m_write = m_write;
                done_flag[own] = 1'b1;
                stall_cnt = 0;
                grant_log.push_back(own);
            end else if (active[own] && (m_read || m_write)) begin
                check("owner_stall", 64'(c_wait[own]), 64'(1));
            end
        end
    endtask

    // One clock: retire/issue requests, drive ports, answer as the RAM, then sample.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        for (int k = 0; k < N; k++)
            if (active[k] && done_flag[k]) begin
                active[k]    = 1'b0;
                done_flag[k] = 1'b0;
            end
        for (int k = 0; k < N; k++)
            if (!active[k] && pq[k].size() != 0) begin
                cur[k] = pq[k].pop_front();
                active[k] = 1'b1;
                sb[k].push_back(cur[k]);
                req_cycle[k] = cyc;
                seen_permit[k] = 1'b0;
            end
        drive_ports();
        for (int k = 0; k < N; k++)
            if (prev_atomic[k] && !c_atomic[k]) fall_cycle[k] = cyc;
        prev_atomic = c_atomic;
        #1;
        if (m_read || m_write) begin
            m_data_r = rd_fn(m_addr);
            if (stall_cnt < stall_target) begin
                m_wait = 1'b1;
                stall_cnt++;
            end else begin
                m_wait = 1'b0;
            end
        end else begin
            m_wait    = 1'b1;
            m_data_r  = '0;
            stall_cnt = 0;
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        if (busy()) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout_%s: still busy after %0d cycles", name, budget);
            clear_all();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{port:3, rd:1'b0, wr:1'b1, addr:32'hFFFF_FFFC, data:32'hDEAD_BEEF, stall:0, exp_read:1'b0, exp_write:1'b1};
        vecs[1] = '{port:2, rd:1'b1, wr:1'b0, addr:32'h0000_0100, data:32'h0,         stall:1, exp_read:1'b1, exp_write:1'b0};
        vecs[2] = '{port:1, rd:1'b1, wr:1'b1, addr:32'h0000_0055, data:32'h0000_1234, stall:0, exp_read:1'b0, exp_write:1'b1};
        vecs[3] = '{port:0, rd:1'b1, wr:1'b0, addr:32'h0000_0000, data:32'h0,         stall:3, exp_read:1'b1, exp_write:1'b0};
        vecs[4] = '{port:3, rd:1'b1, wr:1'b1, addr:32'hAAAA_5555, data:32'h0,         stall:2, exp_read:1'b0, exp_write:1'b1};
        vecs[5] = '{port:1, rd:1'b0, wr:1'b1, addr:32'h7FFF_FFFF, data:32'hFFFF_FFFF, stall:0, exp_read:1'b0, exp_write:1'b1};

        rst_n = 1'b0;
        clear_all();
        last_m_read  = 1'b0;
        last_m_write = 1'b0;

        // Reset state: no permit, RAM idle, pending requests all stalled.
        c_read  = 4'b0110;
        c_write = 4'b1000;
        #3;
        check("rst_permit", 64'(c_permit), 64'(0));
        check("rst_strobes", 64'({m_read, m_write}), 64'(0));
        check("rst_addr", 64'(m_addr), 64'(0));
        check("rst_wdata", 64'(m_data_w), 64'(0));
        check("rst_wait", 64'(c_wait), 64'(4'b1110));
        clear_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single write with a 2-cycle RAM stall.
        stall_target = 2;
        pq[0].push_back('{rd:1'b0, wr:1'b1, addr:32'd39, data:32'd1115, atomic:1'b0});
        step();
        check("sw_no_grant_yet", 64'(c_permit), 64'(0));
        step();
        check("sw_grant", 64'(c_permit), 64'(4'b0001));
        check("sw_addr", 64'(m_addr), 64'(39));
        check("sw_wdata", 64'(m_data_w), 64'(1115));
        check("sw_strobe", 64'({m_read, m_write}), 64'(2'b01));
        check("sw_wait0", 64'(c_wait[0]), 64'(1));
        run_until_idle("single", 20);
        check("sw_release", 64'(c_permit), 64'(0));
        check("sw_latency", 64'(grant_cycle[0] - req_cycle[0]), 64'(1));

        // Reset asserted mid-transfer: outputs drop before any clock edge.
        stall_target = 10;
        pq[1].push_back('{rd:1'b0, wr:1'b1, addr:32'h44, data:32'h99, atomic:1'b0});
        step();
        step();
        check("mid_grant", 64'(c_permit), 64'(4'b0010));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_strobes", 64'({m_read, m_write}), 64'(0));
        check("mid_rst_addr", 64'(m_addr), 64'(0));
        check("mid_rst_wdata", 64'(m_data_w), 64'(0));
        check("mid_rst_permit", 64'(c_permit), 64'(0));
        check("mid_rst_wait", 64'(c_wait), 64'(4'b0010));
        clear_all();
        grant_log.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Contention from rr_ptr=0: port 0 then port 2.
        stall_target = 1;
        grant_log.delete();
        pq[0].push_back('{rd:1'b1, wr:1'b0, addr:32'h10, data:32'h0, atomic:1'b0});
        pq[2].push_back('{rd:1'b1, wr:1'b0, addr:32'h20, data:32'h0, atomic:1'b0});
        run_until_idle("contention", 30);
        check("cont_count", 64'(grant_log.size()), 64'(2));
        check("cont_first", 64'(grant_log[0]), 64'(0));
        check("cont_second", 64'(grant_log[1]), 64'(2));

        // Wrap from rr_ptr=3: port 3 then port 0.
        grant_log.delete();
        pq[3].push_back('{rd:1'b0, wr:1'b1, addr:32'h30, data:32'h3333, atomic:1'b0});
        pq[0].push_back('{rd:1'b0, wr:1'b1, addr:32'h40, data:32'h4444, atomic:1'b0});
        run_until_idle("wrap", 30);
        check("wrap_first", 64'(grant_log[0]), 64'(3));
        check("wrap_second", 64'(grant_log[1]), 64'(0));

        // rr_ptr must now be 1: port 1 beats port 0.
        grant_log.delete();
        pq[0].push_back('{rd:1'b1, wr:1'b0, addr:32'h50, data:32'h0, atomic:1'b0});
        pq[1].push_back('{rd:1'b1, wr:1'b0, addr:32'h60, data:32'h0, atomic:1'b0});
        run_until_idle("ptr", 30);
        check("ptr_first", 64'(grant_log[0]), 64'(1));
        check("ptr_second", 64'(grant_log[1]), 64'(0));

        // Table of single-port transactions.
        for (int i = 0; i < 6; i++) begin
            stall_target = vecs[i].stall;
            pq[vecs[i].port].push_back('{rd:vecs[i].rd, wr:vecs[i].wr, addr:vecs[i].addr,
                                         data:vecs[i].data, atomic:1'b0});
            run_until_idle($sformatf("vec%0d", i), 40);
            check($sformatf("vec%0d_read", i), 64'(last_m_read), 64'(vecs[i].exp_read));
            check($sformatf("vec%0d_write", i), 64'(last_m_write), 64'(vecs[i].exp_write));
            check($sformatf("vec%0d_latency", i),
                  64'(grant_cycle[vecs[i].port] - req_cycle[vecs[i].port]), 64'(1));
        end

        // Atomic hold: port 1 reads then writes 67; port 2 waits for the lock to drop.
        stall_target = 1;
        grant_log.delete();
        pq[1].push_back('{rd:1'b1, wr:1'b0, addr:32'd67, data:32'h0,     atomic:1'b1});
        pq[1].push_back('{rd:1'b0, wr:1'b1, addr:32'd67, data:32'd7777, atomic:1'b1});
        step();
        step();
        check("atom_grant", 64'(c_permit), 64'(4'b0010));
        pq[2].push_back('{rd:1'b1, wr:1'b0, addr:32'h200, data:32'h0, atomic:1'b0});
        run_until_idle("atomic", 40);
        check("atom_count", 64'(grant_log.size()), 64'(3));
        check("atom_first", 64'(grant_log[0]), 64'(1));
        check("atom_second", 64'(grant_log[1]), 64'(1));
        check("atom_third", 64'(grant_log[2]), 64'(2));
        check("atom_after_fall", 64'(grant_cycle[2] > fall_cycle[1]), 64'(1));
        check("atom_regrant_2clk", 64'(grant_cycle[2] - fall_cycle[1] <= 2), 64'(1));

        step();
        check("final_idle", 64'(c_permit), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
